// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: valid/ready data-memory target with fixed wait states and error flagging.
// Define DMEM_ACCESS_CNT_EN to add the rd/wr/err access counters.
module dmem_wait_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
`ifdef DMEM_ACCESS_CNT_EN
   ,
   output logic [15:0] rd_cnt_o,
   output logic [15:0] wr_cnt_o,
   output logic [15:0] err_cnt_o
`endif
);
   localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   if (WAIT_CYCLES > 15) begin : g_wait_chk
      $error("WAIT_CYCLES must be in 0..15");
   end

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d, err_q, err_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [31:0]   off;
   logic          acc_err, accept, enter_resp, rsp_hs;
   logic          c_we, c_err;
   logic [IW-1:0] c_idx;
   logic [31:0]   c_wdata;

   // Unsigned compare against the base first, so addresses below it never alias into range.
   assign off     = req_addr_i - ADDR_BASE;
   assign acc_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i < ADDR_BASE) || ((off >> 2) >= 32'(DEPTH_WORDS));
   assign accept  = (state_q == S_IDLE) && req_valid_i;
   assign rsp_hs  = (state_q == S_RESP) && rsp_ready_i;

   // With no wait states the access completes on the accept edge, straight from the request inputs.
   assign enter_resp = (WC == 4'd0) ? accept : (state_q == S_WAIT) && (cnt_q == 4'd1);
   assign c_we       = (WC == 4'd0) ? req_we_i : we_q;
   assign c_err      = (WC == 4'd0) ? acc_err : err_q;
   assign c_idx      = (WC == 4'd0) ? off[IW+1:2] : idx_q;
   assign c_wdata    = (WC == 4'd0) ? req_wdata_i : wdata_q;

   assign we_d    = accept ? req_we_i : we_q;
   assign err_d   = accept ? acc_err : err_q;
   assign idx_d   = accept ? off[IW+1:2] : idx_q;
   assign wdata_d = accept ? req_wdata_i : wdata_q;
   assign rdata_d = enter_resp ? ((c_we || c_err) ? 32'h0 : mem_q[c_idx]) : rsp_hs ? 32'h0 : rdata_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = (WC == 4'd0) ? S_RESP : S_WAIT;
         cnt_d   = WC;
      end else if (state_q == S_WAIT) begin
         state_d = (cnt_q == 4'd1) ? S_RESP : S_WAIT;
         cnt_d   = cnt_q - 4'd1;
      end else if (rsp_hs) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enter_resp && c_we && !c_err) mem_q[c_idx] <= c_wdata;
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = (state_q == S_RESP) && err_q;

`ifdef DMEM_ACCESS_CNT_EN
   logic [15:0] rd_q, wr_q, ec_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q <= 16'h0;
         wr_q <= 16'h0;
         ec_q <= 16'h0;
      end else if (rsp_hs) begin
         ec_q <= err_q ? ec_q + 16'h1 : ec_q;
         wr_q <= (!err_q && we_q) ? wr_q + 16'h1 : wr_q;
         rd_q <= (!err_q && !we_q) ? rd_q + 16'h1 : rd_q;
      end
   end

   assign rd_cnt_o  = rd_q;
   assign wr_cnt_o  = wr_q;
   assign err_cnt_o = ec_q;
`endif
endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder: randomized scoreboard bench for dmem_wait_responder (WAIT=2 and WAIT=0 instances).
module tb_dmem_wait_responder;
   localparam int W = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_ni;
   logic        req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i, rsp_err_o;
   logic [31:0] req_addr_i, req_wdata_i, rsp_rdata_o;
   logic        v0, rdy0, we0, rv0, rr0, err0;
   logic [31:0] a0, d0, rd0;
`ifdef DMEM_ACCESS_CNT_EN
   logic [15:0] rd_cnt, wr_cnt, err_cnt, rd_cnt0, wr_cnt0, err_cnt0;
`endif

   dmem_wait_responder #(.DEPTH_WORDS(64), .ADDR_BASE(32'h0), .WAIT_CYCLES(W)) u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
`ifdef DMEM_ACCESS_CNT_EN
      , .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .err_cnt_o(err_cnt)
`endif
   );

   dmem_wait_responder #(.DEPTH_WORDS(64), .ADDR_BASE(32'h0), .WAIT_CYCLES(0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(v0), .req_ready_o(rdy0),
      .req_we_i(we0), .req_addr_i(a0), .req_wdata_i(d0),
      .rsp_valid_o(rv0), .rsp_ready_i(rr0), .rsp_rdata_o(rd0), .rsp_err_o(err0)
`ifdef DMEM_ACCESS_CNT_EN
      , .rd_cnt_o(rd_cnt0), .wr_cnt_o(wr_cnt0), .err_cnt_o(err_cnt0)
`endif
   );

   typedef struct { logic [31:0] rdata; logic err; int acc; } exp_t;
   exp_t        q[$];
   logic [31:0] mm [64];
   int checks = 0, errors = 0, edge_n = 0, rr_mode = 0;
   int m_rd = 0, m_wr = 0, m_er = 0;
   bit seen = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   // Reference: byte-addressed 256-byte window of 64 words; anything misaligned or >= 256 is an error.
   task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input bit push);
      int t = 0;
      bit e;
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d;
      while (!req_ready_o && t < 200) begin @(negedge clk); t++; end
      if (!req_ready_o) begin
         chk("accept_timeout", 32'(req_ready_o), 32'h1);
         req_valid_i = 1'b0;
         return;
      end
      if (push) begin
         e = (a[1:0] != 2'b00) || (a >= 32'd256);
         q.push_back('{(we || e) ? 32'h0 : mm[a[7:2]], e, edge_n + 1});
         if (e) m_er++; else if (we) m_wr++; else m_rd++;
         if (we && !e) mm[a[7:2]] = d;
      end
      @(posedge clk);
      #1 req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q.size() != 0 || rsp_valid_o) && t < 1000) begin @(negedge clk); t++; end
      chk("drain_pending", 32'(q.size()), 32'h0);
   endtask

   always @(negedge clk) begin
      if (rst_ni && rsp_valid_o) begin
         if (q.size() == 0) chk("spurious_rsp", 32'h1, 32'h0);
         else begin
            if (!seen) begin
               chk("latency", 32'(edge_n - q[0].acc), 32'(W));
               seen = 1'b1;
            end
            chk("rdata", rsp_rdata_o, q[0].rdata);
            chk("err", 32'(rsp_err_o), 32'(q[0].err));
            chk("req_ready_busy", 32'(req_ready_o), 32'h0);
            if (rsp_ready_i) begin
               void'(q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      rsp_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1 rsp_ready_i = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      end
   end

   initial begin
      int t;
      logic [31:0] a;
      rst_ni = 1'b0;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
      v0 = 1'b0; we0 = 1'b0; a0 = 32'h0; d0 = 32'h0; rr0 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready_o), 32'h1);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("rst_rdata", rsp_rdata_o, 32'h0);
      chk("rst_err", 32'(rsp_err_o), 32'h0);
      chk("rst_req_ready0", 32'(rdy0), 32'h1);
      chk("rst_rsp_valid0", 32'(rv0), 32'h0);
      rst_ni = 1'b1;

      for (int i = 0; i < 64; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b1);
      issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 1'b1);
      issue(1'b1, 32'h12, 32'h11111111, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 1'b1);
      issue(1'b0, 32'h100, 32'h0, 1'b1);
      issue(1'b0, 32'hFC, 32'h0, 1'b1);
      issue(1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1);
      drain();

      // Hold the response for 5 cycles while a competing request waits.
      rr_mode = 2;
      issue(1'b0, 32'h10, 32'h0, 1'b1);
      t = 0;
      while (!rsp_valid_o && t < 50) begin @(negedge clk); t++; end
      chk("stall_rsp_seen", 32'(rsp_valid_o), 32'h1);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h40; req_wdata_i = 32'h0BADF00D;
      repeat (5) @(negedge clk);
      chk("stall_req_ready", 32'(req_ready_o), 32'h0);
      rr_mode = 0;
      issue(1'b1, 32'h40, 32'h0BADF00D, 1'b1);
      drain();

      rr_mode = 1;
      for (int i = 0; i < 300; i++) begin
         t = $urandom_range(0, 9);
         a = (t < 7) ? 32'($urandom_range(0, 63) * 4) :
             (t == 7) ? 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3)) :
             (t == 8) ? 32'(256 + $urandom_range(0, 255) * 4) : 32'hFFFF_FFFC;
         issue($urandom_range(0, 1) == 1, a, $urandom, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rr_mode = 0;
      drain();

      // Reset while a store is in its wait states: the store must be dropped.
      issue(1'b1, 32'h20, 32'hA5A5A5A5, 1'b1);
      drain();
      issue(1'b1, 32'h20, 32'h12345678, 1'b0);
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("midrst_req_ready", 32'(req_ready_o), 32'h1);
      m_rd = 0; m_wr = 0; m_er = 0;
      @(negedge clk);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk);
      chk("postrst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      issue(1'b0, 32'h20, 32'h0, 1'b1);
      issue(1'b1, 32'h24, 32'h77, 1'b1);
      issue(1'b0, 32'h25, 32'h0, 1'b1);
      drain();
`ifdef DMEM_ACCESS_CNT_EN
      chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
      chk("rd_cnt", 32'(rd_cnt), 32'(m_rd));
      chk("err_cnt", 32'(err_cnt), 32'(m_er));
`endif

      // Zero-wait instance: response one cycle after accept, no accept on the handshake edge.
      @(negedge clk);
      v0 = 1'b1; we0 = 1'b1; a0 = 32'h4; d0 = 32'hCAFEF00D;
      chk("w0_req_ready", 32'(rdy0), 32'h1);
      @(posedge clk); #1 v0 = 1'b0;
      chk("w0_st_valid", 32'(rv0), 32'h1);
      chk("w0_st_err", 32'(err0), 32'h0);
      chk("w0_st_rdata", rd0, 32'h0);
      @(negedge clk);
      v0 = 1'b1; we0 = 1'b0; a0 = 32'h4;
      chk("w0_busy_ready", 32'(rdy0), 32'h0);
      @(posedge clk); #1;
      chk("w0_hs_valid", 32'(rv0), 32'h0);
      chk("w0_hs_ready", 32'(rdy0), 32'h1);
      @(posedge clk); #1 v0 = 1'b0;
      chk("w0_ld_valid", 32'(rv0), 32'h1);
      chk("w0_ld_rdata", rd0, 32'hCAFEF00D);
      @(posedge clk); #1;
      chk("w0_ld_done", 32'(rv0), 32'h0);
      @(negedge clk);
      v0 = 1'b1; we0 = 1'b0; a0 = 32'h5;
      @(posedge clk); #1 v0 = 1'b0;
      chk("w0_mis_err", 32'(err0), 32'h1);
      chk("w0_mis_rdata", rd0, 32'h0);
      @(posedge clk); #1;
`ifdef DMEM_ACCESS_CNT_EN
      chk("w0_wr_cnt", 32'(wr_cnt0), 32'h1);
      chk("w0_rd_cnt", 32'(rd_cnt0), 32'h1);
      chk("w0_err_cnt", 32'(err_cnt0), 32'h1);
`endif
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
